// File: rtl/gen_transpose_sched.sv
// Row-in / column-out transpose sequencer: fills a NUM x WID bit matrix, then drains WID columns.
// Latency: first column is valid the cycle after the block-ending row accept.
// Backpressure: columns hold while out_ready=0; in_ready stays low for the whole drain.
module gen_transpose_sched #(
   parameter int NUM = 8,
   parameter int WID = 6
) (
   input  logic           clock,
   input  logic           rst,
   input  logic [WID-1:0] in_data,
   input  logic           in_valid,
   input  logic           in_last,
   output logic           in_ready,
   input  logic           rev_en,
   output logic [NUM-1:0] out_data,
   output logic           out_valid,
   output logic           out_last,
   input  logic           out_ready,
   output logic           busy,
   output logic           len_err
);
   localparam int RW = $clog2(NUM + 1);
   localparam int CW = $clog2(WID);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN} state_t;

   state_t         r_state;
   logic [WID-1:0] r_mat [NUM];
   logic [NUM-1:0] r_mask;
   logic [RW-1:0]  r_row_cnt;
   logic [CW-1:0]  r_col_cnt;
   logic           r_rev;
   logic           r_in_rdy;
   logic           r_out_vld;
   logic           r_out_last;
   logic [NUM-1:0] r_out_dat;
   logic           r_busy;
   logic           r_len_err;

   logic           w_acc;
   logic           w_rev;
   logic           w_end_row;
   logic           w_col_acc;
   logic [RW-1:0]  w_wr_idx;
   logic [NUM-1:0] w_wr_hit;
   logic [WID-1:0] w_eff [NUM];
   logic [CW-1:0]  w_col_sel;
   logic [NUM-1:0] w_col;

   assign w_acc     = in_valid & r_in_rdy;
   assign w_wr_idx  = (r_state == S_IDLE) ? '0 : r_row_cnt;
   assign w_rev     = (r_state == S_IDLE) ? rev_en : r_rev;
   assign w_end_row = (r_row_cnt == RW'(NUM - 1));
   assign w_col_acc = r_out_vld & out_ready;
   assign w_col_sel = (r_state == S_DRAIN) ? r_col_cnt + CW'(1) : '0;

   // Effective matrix includes the row being written this cycle, so column 0
   // can be registered on the same edge that accepts the final row.
   always_comb begin
      for (int r = 0; r < NUM; r++) begin
         w_wr_hit[r] = w_acc && (w_wr_idx == RW'(r));
         w_eff[r]    = w_wr_hit[r] ? in_data : (r_mask[r] ? r_mat[r] : '0);
      end
      for (int r = 0; r < NUM; r++) begin
         w_col[r] = w_rev ? w_eff[NUM-1-r][w_col_sel] : w_eff[r][w_col_sel];
      end
   end

   always_ff @(posedge clock) begin
      for (int r = 0; r < NUM; r++) begin
         if (w_wr_hit[r]) r_mat[r] <= in_data;
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_mask     <= '0;
         r_row_cnt  <= '0;
         r_col_cnt  <= '0;
         r_rev      <= 1'b0;
         r_in_rdy   <= 1'b1;
         r_out_vld  <= 1'b0;
         r_out_last <= 1'b0;
         r_out_dat  <= '0;
         r_busy     <= 1'b0;
         r_len_err  <= 1'b0;
      end else begin
         r_len_err <= 1'b0;
         r_mask    <= r_mask | w_wr_hit;
         case (r_state)
            S_IDLE: begin
               if (w_acc) begin
                  r_row_cnt <= RW'(1);
                  r_rev     <= rev_en;
                  r_busy    <= 1'b1;
                  if (in_last) begin
                     r_state    <= S_DRAIN;
                     r_in_rdy   <= 1'b0;
                     r_out_dat  <= w_col;
                     r_out_vld  <= 1'b1;
                     r_out_last <= 1'b0;
                     r_col_cnt  <= '0;
                  end else begin
                     r_state <= S_FILL;
                  end
               end
            end
            S_FILL: begin
               if (w_acc) begin
                  r_row_cnt <= r_row_cnt + RW'(1);
                  if (in_last || w_end_row) begin
                     r_state    <= S_DRAIN;
                     r_in_rdy   <= 1'b0;
                     r_out_dat  <= w_col;
                     r_out_vld  <= 1'b1;
                     r_out_last <= 1'b0;
                     r_col_cnt  <= '0;
                     r_len_err  <= w_end_row & ~in_last;
                  end
               end
            end
            S_DRAIN: begin
               if (w_col_acc) begin
                  if (r_col_cnt == CW'(WID - 1)) begin
                     r_state    <= S_IDLE;
                     r_in_rdy   <= 1'b1;
                     r_busy     <= 1'b0;
                     r_out_vld  <= 1'b0;
                     r_out_last <= 1'b0;
                     r_out_dat  <= '0;
                     r_row_cnt  <= '0;
                     r_col_cnt  <= '0;
                     r_rev      <= 1'b0;
                     r_mask     <= '0;
                  end else begin
                     r_col_cnt  <= r_col_cnt + CW'(1);
                     r_out_dat  <= w_col;
                     r_out_last <= (r_col_cnt == CW'(WID - 2));
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_rdy;
   assign out_data  = r_out_dat;
   assign out_valid = r_out_vld;
   assign out_last  = r_out_last;
   assign busy      = r_busy;
   assign len_err   = r_len_err;

endmodule
